// File: rtl/proc_pkg.sv
// Shared types and widths for the program sequencer and the fetch stage it controls.
package proc_pkg;

  localparam int PROG_W = 2;
  localparam int PC_W   = 10;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} seq_state_t;

  typedef logic [PROG_W-1:0] prog_idx_t;

  function automatic prog_idx_t next_prog(input prog_idx_t cur, input prog_idx_t last);
    return (cur == last) ? '0 : prog_idx_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// o_nxt is the value the counter would take on an enabled cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt
);

  logic [W-1:0] r_cnt;

  assign o_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_nxt;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: holds fetch in Init, releases it for one program, reports Done with a RUN cycle count.
// Optional RUN-cycle watchdog enabled by defining PROG_WATCHDOG_EN.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int          NUM_PROGS   = 3,
  parameter int          INIT_CYCLES = 2,
  parameter int          CYC_W       = 16,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              Init,
  input  logic              Start,
  input  logic              Halt_in,
  output logic              CoreInit,
  output logic [PROG_W-1:0] ProgState,
  output logic              Busy,
  output logic              Done,
  output logic [CYC_W-1:0]  CycleCount,
  output logic              Timeout
);

  localparam int                INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);
  localparam prog_idx_t         PROG_LAST = PROG_W'(NUM_PROGS - 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  prog_idx_t         r_prog;
  logic [CYC_W-1:0]  r_cyc;
  logic [INIT_W-1:0] w_init_cnt;
  logic [INIT_W-1:0] w_init_nxt_unused;
  logic [CYC_W-1:0]  w_run_cnt_unused;
  logic [CYC_W-1:0]  w_run_nxt;
  logic              w_run_end;
  logic              w_wd_hit;

  // Both counters restart from zero each time their state is entered.
  sat_counter #(.W(INIT_W)) u_init_cnt (
    .clk   (CLK),
    .i_rst (Init),
    .i_clr (r_state != INIT),
    .i_en  (r_state == INIT),
    .o_cnt (w_init_cnt),
    .o_nxt (w_init_nxt_unused)
  );

  sat_counter #(.W(CYC_W)) u_run_cnt (
    .clk   (CLK),
    .i_rst (Init),
    .i_clr (r_state != RUN),
    .i_en  (r_state == RUN),
    .o_cnt (w_run_cnt_unused),
    .o_nxt (w_run_nxt)
  );

`ifdef PROG_WATCHDOG_EN
  logic r_tmo;

  assign w_wd_hit = (w_run_nxt == CYC_W'(TIMEOUT));

  // Halt takes priority, so Timeout is only set when the watchdog alone ended the run.
  always_ff @(posedge CLK) begin
    if (Init) begin
      r_tmo <= 1'b0;
    end else if (w_run_end) begin
      r_tmo <= ~Halt_in;
    end
  end

  assign Timeout = r_tmo;
`else
  logic w_tmo_unused;

  assign w_tmo_unused = ^TIMEOUT;
  assign w_wd_hit     = 1'b0;
  assign Timeout      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_run_end   = 1'b0;
    case (r_state)
      IDLE: if (Start) w_state_nxt = INIT;
      INIT: if (w_init_cnt == INIT_LAST) w_state_nxt = RUN;
      RUN: begin
        if (Halt_in || w_wd_hit) begin
          w_run_end   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Count and program index are captured on entry to DONE so they are valid with the Done pulse.
  always_ff @(posedge CLK) begin
    if (Init) begin
      r_state <= IDLE;
      r_prog  <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_run_end) begin
        r_cyc  <= w_run_nxt;
        r_prog <= next_prog(r_prog, PROG_LAST);
      end
    end
  end

  assign CoreInit   = (r_state != RUN);
  assign Busy       = (r_state == INIT) || (r_state == RUN);
  assign Done       = (r_state == DONE);
  assign ProgState  = r_prog;
  assign CycleCount = r_cyc;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: default instance plus a CYC_W=4 instance for saturation.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        Init, Start, Halt_in;
  logic        CoreInit, Busy, Done, Timeout;
  logic [1:0]  ProgState;
  logic [15:0] CycleCount;

  logic        Init4, Start4, Halt4;
  logic        CoreInit4, Busy4, Done4, Timeout4;
  logic [1:0]  ProgState4;
  logic [3:0]  CycleCount4;

  int n_checks = 0;
  int n_fails  = 0;
  int seen_done;

  always #5 clk = ~clk;

  prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .CYC_W(16), .TIMEOUT(16'hFFFF)) dut (
    .CLK(clk), .Init(Init), .Start(Start), .Halt_in(Halt_in),
    .CoreInit(CoreInit), .ProgState(ProgState), .Busy(Busy), .Done(Done),
    .CycleCount(CycleCount), .Timeout(Timeout)
  );

  prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .CYC_W(4), .TIMEOUT(16'hFFFF)) dut4 (
    .CLK(clk), .Init(Init4), .Start(Start4), .Halt_in(Halt4),
    .CoreInit(CoreInit4), .ProgState(ProgState4), .Busy(Busy4), .Done(Done4),
    .CycleCount(CycleCount4), .Timeout(Timeout4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    Init = 1'b1; Start = 1'b0; Halt_in = 1'b0;
    Init4 = 1'b1; Start4 = 1'b0; Halt4 = 1'b0;

    // Reset held for three cycles
    tick(3);
    check("rst_coreinit", CoreInit, 1);
    check("rst_progstate", ProgState, 0);
    check("rst_done", Done, 0);
    check("rst_busy", Busy, 0);
    check("rst_cyclecount", CycleCount, 0);
    check("rst_timeout", Timeout, 0);
    check("rst4_cyclecount", CycleCount4, 0);
    check("rst4_coreinit", CoreInit4, 1);
    Init = 1'b0;

    // Single program: 114 RUN cycles including the Halt cycle
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    check("t2_init_busy", Busy, 1);
    check("t2_init_coreinit", CoreInit, 1);
    tick(2);
    check("t2_coreinit_held", CoreInit, 1);
    tick(1);
    check("t2_coreinit_fall", CoreInit, 0);
    check("t2_run_busy", Busy, 1);
    tick(113);
    check("t2_no_early_done", Done, 0);
    Halt_in = 1'b1;
    tick(1);
    Halt_in = 1'b0;
    check("t2_done", Done, 1);
    check("t2_cyclecount", CycleCount, 114);
    check("t2_progstate", ProgState, 1);
    check("t2_done_coreinit", CoreInit, 1);
    check("t2_done_busy", Busy, 0);
    check("t2_timeout", Timeout, 0);
    tick(1);
    check("t2_done_pulse_end", Done, 0);
    check("t2_cyclecount_hold", CycleCount, 114);

    // Start held high across three programs of 10 RUN cycles each
    Init = 1'b1;
    tick(1);
    Init = 1'b0;
    check("t3_rst_progstate", ProgState, 0);
    check("t3_rst_cyclecount", CycleCount, 0);
    Start = 1'b1;
    tick(1);
    for (int p = 0; p < 3; p++) begin
      tick(3);
      check("t3_run", CoreInit, 0);
      tick(9);
      Halt_in = 1'b1;
      tick(1);
      Halt_in = 1'b0;
      if (p == 2) Start = 1'b0;
      check("t3_done", Done, 1);
      check("t3_cyclecount", CycleCount, 10);
      check("t3_progstate", ProgState, (p + 1) % 3);
      tick(1);
      check("t3_idle_done", Done, 0);
      check("t3_idle_busy", Busy, 0);
      if (p < 2) begin
        tick(1);
        check("t3_relaunch", Busy, 1);
      end
    end
    tick(1);
    check("t3_stays_idle", Busy, 0);

    // Halt outside RUN is ignored; Init mid-RUN aborts without Done
    Halt_in = 1'b1;
    tick(2);
    check("t4_idle_halt_done", Done, 0);
    check("t4_idle_halt_busy", Busy, 0);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(2);
    check("t4_init_halt_done", Done, 0);
    check("t4_init_halt_busy", Busy, 1);
    tick(1);
    Halt_in = 1'b0;
    check("t4_reach_run", CoreInit, 0);
    tick(5);
    Init = 1'b1;
    tick(1);
    Init = 1'b0;
    check("t4_abort_busy", Busy, 0);
    check("t4_abort_coreinit", CoreInit, 1);
    check("t4_abort_done", Done, 0);
    check("t4_abort_progstate", ProgState, 0);
    check("t4_abort_cyclecount", CycleCount, 0);
    tick(1);
    check("t4_abort_no_done", Done, 0);

    // No watchdog in the default build: 1000 cycles without Halt never finish
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (Done !== 1'b0) seen_done++;
    end
    check("t5_no_done_1000", seen_done, 0);
    check("t5_still_busy", Busy, 1);
    Halt_in = 1'b1;
    tick(1);
    Halt_in = 1'b0;
    check("t5_done", Done, 1);
    check("t5_cyclecount", CycleCount, 998);
    check("t5_timeout", Timeout, 0);
    check("t5_progstate", ProgState, 1);

    // CYC_W=4: 20 RUN cycles saturate at 15
    Init4 = 1'b0;
    Start4 = 1'b1;
    tick(1);
    Start4 = 1'b0;
    tick(22);
    check("t6_no_early_done", Done4, 0);
    Halt4 = 1'b1;
    tick(1);
    Halt4 = 1'b0;
    check("t6_done", Done4, 1);
    check("t6_cyclecount_sat", CycleCount4, 15);
    check("t6_timeout", Timeout4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
